// File: rtl/prog_load_ctrl_pkg.sv
// prog_load_ctrl_pkg: shared state encodings and constants for the program-load sequencer
package prog_load_ctrl_pkg;
    typedef enum logic [2:0] {
        PL_INIT = 3'd0,
        PL_RUN  = 3'd1,
        PL_ARM  = 3'd2,
        PL_LOAD = 3'd3,
        PL_ERR  = 3'd4
    } pl_state_e;
    localparam logic [31:0] ZeroWord = 32'h0;
    localparam int DmemSelBit = 14;
    localparam logic [14:0] WordMax = 15'h7FFF;
    function automatic logic [14:0] sat_inc(input logic [14:0] v);
        return (v == WordMax) ? v : v + 15'd1;
    endfunction
endpackage

// File: rtl/prog_load_ctrl_if.sv
// prog_load_ctrl_if: UART programmer write bus between the programmer (master) and the load sequencer (slave)
interface prog_load_ctrl_if;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic [31:0] upg_dat_i;
    logic        upg_done_i;
    logic        upg_rst_o;
    modport master (output upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i, input upg_rst_o);
    modport slave  (input upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i, output upg_rst_o);
endinterface

// File: rtl/prog_load_ctrl_pl_timeout_cnt.sv
// pl_timeout_cnt: clearable up-counter flagging when the count equals a runtime limit
module pl_timeout_cnt #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + W'(1);
    end
    assign tc_o = (cnt_q == limit_i);
endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: switches memories between CPU run and UART upload, routes upload writes, holds CPU reset
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_req,
    prog_load_ctrl_if.slave        upg,
    output logic                   kick_off,
    output logic                   inited,
    output logic                   cpu_rst,
    output logic                   imem_we,
    output logic [13:0]            imem_addr,
    output logic [31:0]            imem_din,
    output logic                   dmem_we,
    output logic [13:0]            dmem_addr,
    output logic [31:0]            dmem_din,
    output logic                   load_err,
    output logic [14:0]            imem_words,
    output logic [14:0]            dmem_words
);
    pl_state_e   state_q;
    logic        upg_rst_q, kick_off_q, inited_q, cpu_rst_q, load_err_q;
    logic        imem_we_q, dmem_we_q;
    logic [13:0] imem_addr_q, dmem_addr_q;
    logic [31:0] imem_din_q, dmem_din_q;
    logic [14:0] imem_words_q, dmem_words_q;
    logic        cnt_en, cnt_clr, tc;
    logic [CNT_W-1:0] limit;

    // One counter serves both the INIT settle period and the LOAD idle timeout
    assign cnt_en  = (state_q == PL_INIT) || (state_q == PL_LOAD);
    assign cnt_clr = !cnt_en || ((state_q == PL_LOAD) && (upg.upg_wen_i || upg.upg_done_i));
    assign limit   = (state_q == PL_INIT) ? CNT_W'(INIT_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES);

    pl_timeout_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .limit_i(limit),
        .tc_o   (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PL_INIT;
            upg_rst_q    <= 1'b1;
            kick_off_q   <= 1'b1;
            inited_q     <= 1'b0;
            cpu_rst_q    <= 1'b1;
            load_err_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            dmem_addr_q  <= '0;
            imem_din_q   <= ZeroWord;
            dmem_din_q   <= ZeroWord;
            imem_words_q <= '0;
            dmem_words_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            case (state_q)
                PL_INIT: if (tc) begin
                    state_q   <= PL_RUN;
                    inited_q  <= 1'b1;
                    cpu_rst_q <= 1'b0;
                end
                PL_RUN, PL_ERR: if (prog_req) begin
                    state_q      <= PL_ARM;
                    kick_off_q   <= 1'b0;
                    upg_rst_q    <= 1'b0;
                    inited_q     <= 1'b0;
                    cpu_rst_q    <= 1'b1;
                    load_err_q   <= 1'b0;
                    imem_words_q <= '0;
                    dmem_words_q <= '0;
                end
                PL_ARM: state_q <= PL_LOAD;
                PL_LOAD: begin
                    if (upg.upg_wen_i && upg.upg_adr_i[DmemSelBit]) begin
                        dmem_we_q    <= 1'b1;
                        dmem_addr_q  <= upg.upg_adr_i[13:0];
                        dmem_din_q   <= upg.upg_dat_i;
                        dmem_words_q <= sat_inc(dmem_words_q);
                    end else if (upg.upg_wen_i) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= upg.upg_adr_i[13:0];
                        imem_din_q   <= upg.upg_dat_i;
                        imem_words_q <= sat_inc(imem_words_q);
                    end
                    // A write coinciding with done still commits; its pulse lands in the first INIT cycle
                    if (upg.upg_done_i) begin
                        state_q    <= PL_INIT;
                        kick_off_q <= 1'b1;
                        upg_rst_q  <= 1'b1;
                    end else if (!upg.upg_wen_i && tc) begin
                        state_q    <= PL_ERR;
                        kick_off_q <= 1'b1;
                        upg_rst_q  <= 1'b1;
                        load_err_q <= 1'b1;
                    end
                end
                default: state_q <= PL_INIT;
            endcase
        end
    end

    assign upg.upg_rst_o = upg_rst_q;
    assign kick_off      = kick_off_q;
    assign inited        = inited_q;
    assign cpu_rst       = cpu_rst_q;
    assign load_err      = load_err_q;
    assign imem_we       = imem_we_q;
    assign dmem_we       = dmem_we_q;
    assign imem_addr     = imem_addr_q;
    assign dmem_addr     = dmem_addr_q;
    assign imem_din      = imem_din_q;
    assign dmem_din      = dmem_din_q;
    assign imem_words    = imem_words_q;
    assign dmem_words    = dmem_words_q;
endmodule
